// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor encodings and default widths
package bp_pkg;

  localparam int DEF_PC_W  = 32;
  localparam int DEF_IDX_W = 6;

  typedef logic [1:0] ctr_t;

  // Two-bit saturating counter states; MSB is the predicted direction.
  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  localparam ctr_t CTR_RESET = WNT;

endpackage

// File: rtl/pht_ctr_update.sv
// rtl/pht_ctr_update.sv - two-bit saturating counter next-value function
module pht_ctr_update
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // Step toward the observed outcome, sticking at the strong states.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// rtl/gshare_pht.sv - gshare direction predictor with speculative GHR
module gshare_pht
  import bp_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_resp_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [IDX_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispredict
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       ctr_q [DEPTH];
  logic [1:0]       ctr_d [DEPTH];
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic             resp_valid_q, resp_valid_d;
  logic             taken_q, taken_d;
  logic [IDX_W-1:0] snap_q, snap_d;

  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic [1:0]       upd_ctr_next;
  logic [1:0]       pred_ctr;
  logic             pred_bit;
  logic             repair;
  logic             accept;

  // Word-aligned PC bits above the index are not hashed.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                            upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

  assign pred_idx = pred_pc[IDX_W+1:2] ^ ghr_q;
  assign upd_idx  = upd_pc[IDX_W+1:2] ^ upd_ghr;
  assign repair   = upd_valid & upd_mispredict;
  assign accept   = pred_valid & ~repair;

  pht_ctr_update u_upd (
    .ctr      (ctr_q[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (upd_ctr_next)
  );

  // Prediction sees the counter as it will be after this cycle's training.
  always_comb begin
    pred_ctr = ctr_q[pred_idx];
    if (upd_valid && (upd_idx == pred_idx)) pred_ctr = upd_ctr_next;
  end

  assign pred_bit = pred_ctr[1];

  // Next-state: table training, GHR repair/shift, response registers.
  always_comb begin
    ctr_d = ctr_q;
    if (upd_valid) ctr_d[upd_idx] = upd_ctr_next;

    ghr_d = ghr_q;
    if (repair)      ghr_d = {upd_ghr[IDX_W-2:0], upd_taken};
    else if (accept) ghr_d = {ghr_q[IDX_W-2:0], pred_bit};

    resp_valid_d = accept;
    taken_d      = accept ? pred_bit : taken_q;
    snap_d       = accept ? ghr_q    : snap_q;
  end

  // State registers; table comes out of reset weakly not-taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RESET;
      ghr_q        <= '0;
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      snap_q       <= '0;
    end else begin
      ctr_q        <= ctr_d;
      ghr_q        <= ghr_d;
      resp_valid_q <= resp_valid_d;
      taken_q      <= taken_d;
      snap_q       <= snap_d;
    end
  end

  assign pred_resp_valid = resp_valid_q;
  assign pred_taken      = taken_q;
  assign pred_ghr        = snap_q;

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Gshare direction predictor: a table of 2^IDX_W two-bit saturating counters plus a speculative global history register (GHR).
- Fetch-stage requests are indexed by PC XOR GHR; the response is a registered taken/not-taken prediction and a GHR snapshot.
- The snapshot travels down the pipe with the branch. Execute sends it back with the resolved outcome to train the table and repair the GHR on a mispredict.
- Sits between fetch (upstream) and the execute-stage branch resolution unit (downstream).

Parameters:
- PC_W, 32, fetch/branch PC width.
- IDX_W, 6, table index width; table depth = 2^IDX_W; GHR width = IDX_W.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- pred_valid  in  1  fetch requests a prediction this cycle.
- pred_pc  in  PC_W  PC of the fetched branch.
- pred_resp_valid  out  1  prediction response valid (one cycle after request).
- pred_taken  out  1  predicted direction (counter MSB).
- pred_ghr  out  IDX_W  GHR value used to form the index (snapshot for execute).
- upd_valid  in  1  a branch resolved this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_ghr  in  IDX_W  snapshot returned with the branch.
- upd_taken  in  1  actual outcome.
- upd_mispredict  in  1  the prediction was wrong; repair the GHR.

Behaviour:
- Reset (async, rstn low):
  - every counter = 2'b01 (weakly not taken);
  - GHR = 0;
  - pred_resp_valid = 0, pred_taken = 0, pred_ghr = 0.
- Index function: idx = pc[IDX_W+1:2] ^ ghr. PC bits [1:0] are ignored.
  - Predict path uses pred_pc with the current GHR.
  - Update path uses upd_pc with upd_ghr.
- Prediction latency is 1 cycle. Request in cycle N produces, in cycle N+1:
  - pred_resp_valid = 1;
  - pred_taken = MSB of counter[idx];
  - pred_ghr = GHR as sampled in cycle N.
  - pred_resp_valid is low in any cycle with no accepted request.
- Speculative GHR: on an accepted request, GHR <= {GHR[IDX_W-2:0], predicted_bit}. predicted_bit is the same value that is registered into pred_taken.
- Counter training (only when upd_valid = 1):
  - taken: counter saturating increment (11 stays 11);
  - not taken: counter saturating decrement (00 stays 00);
  - written at the clock edge.
- GHR repair: upd_valid & upd_mispredict => GHR <= {upd_ghr[IDX_W-2:0], upd_taken}.
- Simultaneous events:
  - Repair wins over the speculative shift.
  - A prediction request in the same cycle as a repair is squashed: no GHR shift, pred_resp_valid = 0 next cycle.
  - Predict idx == update idx in the same cycle (no repair): prediction uses the post-update counter value (write-to-read bypass).
  - Update with upd_mispredict = 0 never touches the GHR.
  - upd_mispredict is ignored when upd_valid = 0.
- No stalls and no backpressure: one request and one update accepted per cycle.
- Reset mid-operation: all state returns to reset values immediately; a pending response is lost.

Decomposition:
- Shared package (bp_pkg):
  - counter encodings: SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11;
  - reset value = WNT;
  - default IDX_W/PC_W.
- One sub-module, pht_ctr_update: combinational 2-bit saturating next-value function (current, taken -> next).
  - Instantiated once for the update path.
  - Its output also feeds the bypass.
- Table held as a flop array (async reset needed for the WNT initial value); no SRAM.

Test Plan:
- Reset, then predict pc=0x100 (idx 0) -> next cycle resp_valid=1, taken=0, pred_ghr=0x00; GHR becomes 0x00.
- Three updates upd_pc=0x14, upd_ghr=0, taken=1 (idx 5) -> counter 01->10->11->11.
  - Then, with GHR forced to 0 via a repair (upd_ghr=0, taken=0), predict pc=0x14 -> taken=1.
- Four not-taken updates on idx 5 from 11 -> 10, 01, 00, 00 (saturates).
  - Predict -> taken=0.
- Six predictions returning taken (idx pre-trained to 11) from GHR=0 -> GHR shifts 0x01, 0x03 ... 0x3F.
  - Each pred_ghr equals the pre-shift value.
- Mispredict upd_ghr=0x2A, upd_taken=1, plus a same-cycle pred_valid -> GHR=0x15, next-cycle resp_valid=0.
- Same-cycle predict and update on idx 7 with counter=01, upd_taken=1 -> pred_taken=1 (bypass); counter=10.
